// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a single
// word-wide RAM. One transaction at a time. Data requests have priority. A
// fetch request is granted once the data port has won STARVE_LIMIT grants in a
// row while the fetch request was waiting. Load results are extended to
// 32 bits. Store data is placed on the byte lanes with the matching byte
// enables. A misaligned access or an illegal funct3 completes as a fault and
// does not touch the RAM.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   f_req, f_addr                    fetch request and byte address
//   f_done, f_rdata, f_err           fetch completion pulse, word, misalign flag
//   d_req, d_we, d_op, d_addr,
//   d_wdata                          load/store request (d_op = RV32 funct3)
//   d_done, d_rdata, d_err           data completion pulse, load value, fault
//   ram_req, ram_we, ram_addr,
//   ram_be, ram_wdata                RAM command, driven only in ISSUE
//   ram_rdata                        RAM read word, valid the cycle after ram_req
//
// state | meaning
// IDLE  | sample requests, arbitrate, latch the winner
// ISSUE | drive the RAM command
// RESP  | pulse done on the granted port, return read data
// FAULT | pulse done + err on the granted port, no RAM access
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_done,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_op,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, FAULT} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  streak_q, streak_d;
  logic           is_f_q, is_f_d;
  logic           we_q, we_d;
  logic [2:0]     op_q, op_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;

  logic           grant_d, grant_f;
  logic           d_fault, f_fault;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
      is_f_q   <= 1'b0;
      we_q     <= 1'b0;
      op_q     <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      is_f_q   <= is_f_d;
      we_q     <= we_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Arbitration and fault classification on the live request inputs
  always_comb begin
    grant_d = d_req && !(f_req && (streak_q == LIMIT));
    grant_f = f_req && !grant_d;
    f_fault = (f_addr[1:0] != 2'b00);
    d_fault = 1'b0;
    case (d_op)
      3'd1, 3'd5: d_fault = d_addr[0];
      3'd2:       d_fault = (d_addr[1:0] != 2'b00);
      3'd3, 3'd6, 3'd7: d_fault = 1'b1;
      default:    d_fault = 1'b0;
    endcase
    // LBU/LHU encodings have no store counterpart
    if (d_we && (d_op == 3'd4 || d_op == 3'd5)) d_fault = 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    is_f_d   = is_f_q;
    we_d     = we_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          is_f_d  = 1'b0;
          we_d    = d_we;
          op_d    = d_op;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          state_d = d_fault ? FAULT : ISSUE;
          // streak only grows while fetch is actually waiting
          if (f_req) streak_d = (streak_q == LIMIT) ? streak_q : streak_q + SW'(1);
          else       streak_d = '0;
        end else if (grant_f) begin
          is_f_d   = 1'b1;
          we_d     = 1'b0;
          op_d     = 3'd2;
          addr_d   = f_addr;
          wdata_d  = 32'd0;
          state_d  = f_fault ? FAULT : ISSUE;
          streak_d = '0;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  logic [31:0] lane_w;
  logic [15:0] half_w;
  logic [31:0] load_ext;
  logic [3:0]  be_w;
  logic [31:0] wdata_w;

  always_comb begin
    lane_w = ram_rdata >> {addr_q[1:0], 3'b000};
    half_w = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (op_q)
      3'd0:    load_ext = {{24{lane_w[7]}}, lane_w[7:0]};
      3'd1:    load_ext = {{16{half_w[15]}}, half_w};
      3'd4:    load_ext = {24'd0, lane_w[7:0]};
      3'd5:    load_ext = {16'd0, half_w};
      default: load_ext = ram_rdata;
    endcase

    // reads always fetch the whole word; lane selection happens on return
    be_w    = 4'b1111;
    wdata_w = wdata_q;
    if (we_q) begin
      case (op_q[1:0])
        2'd0: begin
          be_w    = 4'b0001 << addr_q[1:0];
          wdata_w = {4{wdata_q[7:0]}};
        end
        2'd1: begin
          be_w    = addr_q[1] ? 4'b1100 : 4'b0011;
          wdata_w = {2{wdata_q[15:0]}};
        end
        default: be_w = 4'b1111;
      endcase
    end

    ram_req   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = 32'd0;
    ram_be    = 4'd0;
    ram_wdata = 32'd0;
    f_done    = 1'b0;
    f_rdata   = 32'd0;
    f_err     = 1'b0;
    d_done    = 1'b0;
    d_rdata   = 32'd0;
    d_err     = 1'b0;
    case (state_q)
      ISSUE: begin
        ram_req   = 1'b1;
        ram_we    = we_q;
        ram_addr  = {addr_q[31:2], 2'b00};
        ram_be    = be_w;
        ram_wdata = we_q ? wdata_w : 32'd0;
      end
      RESP: begin
        if (is_f_q) begin
          f_done  = 1'b1;
          f_rdata = ram_rdata;
        end else begin
          d_done  = 1'b1;
          d_rdata = we_q ? 32'd0 : load_ext;
        end
      end
      FAULT: begin
        if (is_f_q) begin
          f_done = 1'b1;
          f_err  = 1'b1;
        end else begin
          d_done = 1'b1;
          d_err  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
